// File: rtl/weighted_rr_arbiter_if.sv
// Arbiter request/grant bundle: requester-side master, arbiter-side slave.
// Carries request vector, completion pulse, weight-write port and registered grant outputs.
interface weighted_rr_arbiter_if #(
    parameter int N  = 8,
    parameter int WW = 4,
    parameter int IW = 3
);
    logic [N-1:0]  req;
    logic          done;
    logic          wt_we;
    logic [IW-1:0] wt_idx;
    logic [WW-1:0] wt_data;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_valid;

    modport master (
        output req, done, wt_we, wt_idx, wt_data,
        input  gnt, gnt_idx, gnt_valid
    );

    modport slave (
        input  req, done, wt_we, wt_idx, wt_data,
        output gnt, gnt_idx, gnt_valid
    );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: winner holds the grant for weight[idx] done pulses; optional watchdog under WRR_TIMEOUT_EN.
// Latency: grant registered one cycle after req is sampled; one idle cycle separates consecutive grants.
// Backpressure: none on requesters; a grant is held while req stays high and credit remains.
module weighted_rr_arbiter #(
    parameter int N       = 8,
    parameter int WW      = 4,
    parameter int IW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    weighted_rr_arbiter_if.slave arb_if
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (N < 2 || N > 32 || IW != $clog2(N) || TIMEOUT < 1) begin : g_bad_param
        $error("weighted_rr_arbiter: illegal parameter combination");
    end

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] weight_q [N];
    logic [WW-1:0] weight_d [N];

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          release_now;
    logic          wd_expire;

    // Search starts just after the last released index and ends on it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!win_found && arb_if.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign release_now = (state_q == ST_GRANT) &&
                         ((arb_if.done && credit_q == WW'(1)) ||
                          !arb_if.req[gnt_idx_q] || wd_expire);

`ifdef WRR_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;

    // Expires on the edge where the count of done-free grant cycles reaches TIMEOUT.
    assign wd_expire = (state_q == ST_GRANT) && !arb_if.done &&
                       (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        wd_d = wd_q;
        if (state_q == ST_IDLE) begin
            if (win_found) wd_d = '0;
        end else if (arb_if.done || release_now) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        credit_d    = credit_q;
        ptr_d       = ptr_q;
        weight_d    = weight_q;

        if (state_q == ST_IDLE) begin
            if (win_found) begin
                state_d          = ST_GRANT;
                gnt_d            = '0;
                gnt_d[win_idx]   = 1'b1;
                gnt_idx_d        = win_idx;
                gnt_valid_d      = 1'b1;
                // Reads the pre-write weight, so a same-edge write takes effect next grant.
                credit_d         = (weight_q[win_idx] == '0) ? WW'(1) : weight_q[win_idx];
            end
        end else begin
            if (release_now) begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                ptr_d       = gnt_idx_q;
            end else if (arb_if.done) begin
                credit_d = credit_q - WW'(1);
            end
        end

        if (arb_if.wt_we && int'(arb_if.wt_idx) < N) begin
            weight_d[arb_if.wt_idx] = arb_if.wt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            credit_q    <= '0;
            ptr_q       <= IW'(N - 1);
            for (int i = 0; i < N; i++) weight_q[i] <= WW'(1);
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            credit_q    <= credit_d;
            ptr_q       <= ptr_d;
            for (int i = 0; i < N; i++) weight_q[i] <= weight_d[i];
        end
    end

    assign arb_if.gnt       = gnt_q;
    assign arb_if.gnt_idx   = gnt_idx_q;
    assign arb_if.gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios plus random traffic, scored against a transaction-level model.
module tb_weighted_rr_arbiter;
    localparam int N       = 8;
    localparam int WW      = 4;
    localparam int IW      = 3;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst_n;

    weighted_rr_arbiter_if #(.N(N), .WW(WW), .IW(IW)) ifc ();

    weighted_rr_arbiter #(.N(N), .WW(WW), .IW(IW), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the grant, how many completions it has left,
    // where the round-robin search resumes, and the weight table.
    typedef struct {
        logic          vld;
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   m_owner;
    int   m_credit;
    int   m_ptr;
    int   m_last;
    int   m_stall;
    int   m_wt[N];

    task automatic m_reset();
        m_owner  = -1;
        m_credit = 0;
        m_ptr    = N - 1;
        m_last   = 0;
        m_stall  = 0;
        for (int i = 0; i < N; i++) m_wt[i] = 1;
        exp_q.delete();
    endtask

    task automatic m_step();
        exp_t e;
        bit   rel;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_owner < 0 && ifc.req[j]) begin
                    m_owner  = j;
                    m_last   = j;
                    m_credit = (m_wt[j] == 0) ? 1 : m_wt[j];
                    m_stall  = 0;
                end
            end
        end else begin
            rel = 1'b0;
`ifdef WRR_TIMEOUT_EN
            if (ifc.done) m_stall = 0;
            else begin
                m_stall++;
                if (m_stall >= TIMEOUT) rel = 1'b1;
            end
`endif
            if (!ifc.req[m_owner]) rel = 1'b1;
            if (ifc.done && m_credit == 1) rel = 1'b1;
            if (rel) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (ifc.done) begin
                m_credit--;
            end
        end
        if (ifc.wt_we && int'(ifc.wt_idx) < N) m_wt[ifc.wt_idx] = int'(ifc.wt_data);
        e.vld = (m_owner >= 0);
        e.gnt = '0;
        if (m_owner >= 0) e.gnt[m_owner] = 1'b1;
        e.idx = IW'(m_last);
        exp_q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_gnt", int'(ifc.gnt), 0);
            chk("reset_vld", int'(ifc.gnt_valid), 0);
            chk("reset_idx", int'(ifc.gnt_idx), 0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_gnt", int'(ifc.gnt), int'(e.gnt));
            chk("sb_vld", int'(ifc.gnt_valid), int'(e.vld));
            chk("sb_idx", int'(ifc.gnt_idx), int'(e.idx));
            chk("onehot", ($countones(ifc.gnt) <= 1) ? 1 : 0, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string name);
        for (int i = 0; i < 20 && !ifc.gnt_valid; i++) tick();
        chk(name, int'(ifc.gnt_valid), 1);
    endtask

    int cnt;

    initial begin
        m_reset();
        rst_n       = 1'b0;
        ifc.req     = '0;
        ifc.done    = 1'b0;
        ifc.wt_we   = 1'b0;
        ifc.wt_idx  = '0;
        ifc.wt_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // First grant after reset goes to requester 0 with one-cycle latency.
        ifc.req = 8'b0000_0001;
        tick();
        chk("first_gnt", int'(ifc.gnt), 1);
        chk("first_idx", int'(ifc.gnt_idx), 0);
        chk("first_vld", int'(ifc.gnt_valid), 1);
        ifc.req = '0;
        tick();
        tick();

        // All weights 1, everyone requesting: strict rotation with one idle cycle.
        do_reset();
        ifc.req = 8'hFF;
        wait_gnt("rot_wait");
        for (int g = 0; g < 9; g++) begin
            chk("rot_order", int'(ifc.gnt_idx), g % N);
            ifc.done = 1'b1;
            tick();
            ifc.done = 1'b0;
            chk("rot_gap", int'(ifc.gnt_valid), 0);
            tick();
            chk("rot_regrant", int'(ifc.gnt_valid), 1);
        end
        ifc.done = 1'b1;
        tick();
        ifc.done = 1'b0;
        ifc.req  = '0;
        tick();

        // Weight 3 on requester 2: grant survives two completions, drops on the third.
        ifc.wt_we   = 1'b1;
        ifc.wt_idx  = 3'd2;
        ifc.wt_data = 4'd3;
        tick();
        ifc.wt_we = 1'b0;
        ifc.req   = 8'b0000_0100;
        wait_gnt("wt3_wait");
        for (int d = 1; d <= 3; d++) begin
            ifc.done = 1'b1;
            tick();
            ifc.done = 1'b0;
            chk("wt3_after_done", int'(ifc.gnt_valid), (d < 3) ? 1 : 0);
            if (d < 3) tick();
        end
        tick();
        chk("wt3_regrant_vld", int'(ifc.gnt_valid), 1);
        chk("wt3_regrant_idx", int'(ifc.gnt_idx), 2);
        ifc.req = '0;
        tick();
        tick();

        // Wrap-around: release 7, then requester 0 is next.
        ifc.req = 8'b1000_0000;
        wait_gnt("wrap_wait");
        chk("wrap_idx7", int'(ifc.gnt_idx), 7);
        ifc.req = '0;
        tick();
        chk("wrap_rel", int'(ifc.gnt_valid), 0);
        ifc.req = 8'b0000_0001;
        tick();
        chk("wrap_gnt", int'(ifc.gnt), 1);
        ifc.req = '0;
        tick();
        tick();

        // Request withdrawn without done; search resumes after 5; async reset mid-grant.
        ifc.req = 8'b0010_0000;
        wait_gnt("drop_wait");
        chk("drop_idx5", int'(ifc.gnt_idx), 5);
        ifc.req = '0;
        tick();
        chk("drop_rel", int'(ifc.gnt_valid), 0);
        ifc.req = 8'hFF;
        tick();
        chk("drop_next_idx", int'(ifc.gnt_idx), 6);
        chk("drop_next_vld", int'(ifc.gnt_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", int'(ifc.gnt), 0);
        chk("async_rst_vld", int'(ifc.gnt_valid), 0);
        ifc.req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Grant held with no done: watchdog drops it, otherwise it is held.
        ifc.req = 8'b0000_1000;
        wait_gnt("hold_wait");
        cnt = 1;
        while (ifc.gnt_valid && cnt < 100) begin
            tick();
            if (ifc.gnt_valid) cnt++;
        end
`ifdef WRR_TIMEOUT_EN
        chk("hold_cycles", cnt, TIMEOUT);
        chk("hold_dropped", int'(ifc.gnt_valid), 0);
`else
        chk("hold_cycles", cnt, 100);
        chk("hold_still", int'(ifc.gnt_valid), 1);
`endif
        ifc.req = '0;
        tick();
        tick();

        // Random traffic with weight updates, including weight 0.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 15) ifc.req = N'($urandom);
            ifc.done    = ($urandom_range(0, 99) < 35);
            ifc.wt_we   = ($urandom_range(0, 99) < 10);
            ifc.wt_idx  = IW'($urandom_range(0, N - 1));
            ifc.wt_data = WW'($urandom);
            tick();
        end
        ifc.req   = '0;
        ifc.done  = 1'b0;
        ifc.wt_we = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 Parameter N, default 8, number of requesters (2..32).
REQ-002 Parameter WW, default 4, weight/credit width in bits.
REQ-003 Parameter IW, default 3, index width; SHALL equal clog2(N).
REQ-004 Parameter TIMEOUT, default 255, watchdog limit in cycles (used only under WRR_TIMEOUT_EN).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  N  request vector, bit i = requester i; level-sensitive.
REQ-008 done  input  1  one-cycle pulse from the granted requester: one transaction completed.
REQ-009 wt_we  input  1  weight write strobe.
REQ-010 wt_idx  input  IW  weight write index.
REQ-011 wt_data  input  WW  weight write value.
REQ-012 gnt  output  N  registered one-hot grant, or all-zero.
REQ-013 gnt_idx  output  IW  registered index of current grant; holds last value while gnt_valid=0.
REQ-014 gnt_valid  output  1  registered; high when gnt is non-zero.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-016 IDLE->GRANT: if req != 0 at edge k, gnt/gnt_idx/gnt_valid SHALL be valid after edge k (1-cycle latency).
REQ-017 Winner SHALL be the first set req bit searching ptr+1, ptr+2, ... wrapping N-1->0, ending at ptr; ptr = last released index.
REQ-018 On grant, credit SHALL load weight[winner]; a stored weight of 0 SHALL load as 1.
REQ-019 In GRANT, each edge with done=1 SHALL decrement credit by 1; done while in IDLE SHALL be ignored.
REQ-020 GRANT->IDLE at an edge when (done=1 and credit=1) or req[gnt_idx]=0; gnt SHALL be 0 after that edge and ptr SHALL take gnt_idx.
REQ-021 One idle cycle SHALL separate consecutive grants: earliest next grant appears after edge k+1 when release occurs at edge k.
REQ-022 done=1 with req[gnt_idx]=0 at the same edge SHALL release (single release, no double decrement effect).
REQ-023 Weight writes SHALL update weight[wt_idx] at the edge; wt_idx >= N SHALL be ignored.
REQ-024 A weight write and a credit load for the same index at the same edge SHALL load the old weight.
REQ-025 A weight write SHALL NOT alter the credit of an active grant.
REQ-026 gnt SHALL never have more than one bit set; gnt_valid SHALL equal |gnt every cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, credit=0, ptr=N-1, all weights=1, watchdog=0.
REQ-028 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for clk.
REQ-029 After rst_n rises, requester 0 SHALL have highest priority for the first grant.

Configuration
REQ-030 Macro WRR_TIMEOUT_EN defined: a watchdog counter SHALL clear on grant and on every done, increment each GRANT cycle otherwise, and force release (as in REQ-020) at the edge it reaches TIMEOUT.
REQ-031 Macro WRR_TIMEOUT_EN undefined: no watchdog logic; grant SHALL be held indefinitely while req[gnt_idx]=1 and credit remains.

Verification
REQ-032 Reset, req=8'b0000_0001 -> gnt=8'b0000_0001, gnt_idx=0, gnt_valid=1 one cycle after req sampled.
REQ-033 All weights 1, req=8'hFF, done pulsed every grant -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-034 weight[2]=3, req=8'b0000_0100 held, 3 done pulses -> gnt held through first two, drops after third; next grant to 2 after one idle cycle.
REQ-035 Force ptr=7 (grant and release idx 7), then req=8'b0000_0001 -> gnt=8'b0000_0001 (wrap-around).
REQ-036 Grant to idx 5, deassert req[5] with no done -> gnt=0 next cycle, ptr=5; rst_n low mid-grant -> gnt=0 immediately.
REQ-037 With WRR_TIMEOUT_EN, TIMEOUT=16, grant held with no done -> gnt drops after 16th GRANT cycle; without macro gnt stays high for 100 cycles.
